// File: rtl/paddle_position_tracker.sv
// ============================================================================
// Module   : paddle_position_tracker
// Purpose  : Frame-synchronous paddle Y tracker with pixel-hit and collision query ports.
//            Optional macro PADDLE_WRAP_EN: commit wraps around the Y range instead of clamping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module paddle_position_tracker #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 64,
  parameter int PADDLE_X      = 16,
  parameter int PADDLE_WIDTH  = 8,
  parameter int INIT_Y        = 208,
  parameter int MAX_PENDING   = 15,
  parameter int COORD_W       = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [1:0]         position_change,
  input  logic                      frame_start,
  input  logic                      pixel_valid,
  input  logic [COORD_W-1:0]        pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  output logic                      pixel_on,
  output logic                      pixel_on_valid,
  input  logic                      hit_req,
  input  logic [COORD_W-1:0]        ball_y,
  input  logic [COORD_W-1:0]        ball_height,
  output logic                      hit_ack,
  output logic                      hit,
  output logic signed [COORD_W:0]   hit_offset,
  output logic [COORD_W-1:0]        paddle_y,
  output logic                      at_top,
  output logic                      at_bottom
);

  localparam int c_pend_w = $clog2(MAX_PENDING + 1) + 1;
  localparam int c_sum_w  = COORD_W + 2;

  localparam logic signed [c_pend_w:0]  c_sat_hi = (c_pend_w + 1)'(MAX_PENDING);
  localparam logic signed [c_pend_w:0]  c_sat_lo = -c_sat_hi;
  localparam logic signed [c_sum_w-1:0] c_y_max  = c_sum_w'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0]        c_y_max_u = COORD_W'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0]        c_init_y = COORD_W'(INIT_Y);
  localparam logic [COORD_W:0]          c_x_lo   = (COORD_W + 1)'(PADDLE_X);
  localparam logic [COORD_W:0]          c_x_hi   = (COORD_W + 1)'(PADDLE_X + PADDLE_WIDTH);
  localparam logic [COORD_W:0]          c_ph     = (COORD_W + 1)'(PADDLE_HEIGHT);
  localparam logic [COORD_W:0]          c_ph_half = (COORD_W + 1)'(PADDLE_HEIGHT / 2);

  logic signed [c_pend_w-1:0] r_pending;
  logic [COORD_W-1:0]         r_paddle_y;

  logic signed [1:0]          w_step;
  logic signed [c_pend_w:0]   w_pend_sum;
  logic signed [c_pend_w-1:0] w_pend_sat;
  logic signed [c_sum_w-1:0]  w_y_sum;
  logic signed [c_sum_w-1:0]  w_y_adj;
  logic [COORD_W-1:0]         w_y_next;

  // 2'b10 is not a legal tick and contributes nothing.
  assign w_step = (position_change == 2'sb10) ? 2'sb00 : position_change;

  always_comb begin
    w_pend_sum = $signed({r_pending[c_pend_w-1], r_pending})
               + $signed({{(c_pend_w - 1){w_step[1]}}, w_step});
    w_pend_sat = w_pend_sum[c_pend_w-1:0];
    if (w_pend_sum > c_sat_hi)
      w_pend_sat = c_sat_hi[c_pend_w-1:0];
    else if (w_pend_sum < c_sat_lo)
      w_pend_sat = c_sat_lo[c_pend_w-1:0];
  end

  always_comb begin
    w_y_sum = $signed({2'b00, r_paddle_y})
            + $signed({{(c_sum_w - c_pend_w){r_pending[c_pend_w-1]}}, r_pending});
    w_y_adj = w_y_sum;
`ifdef PADDLE_WRAP_EN
    if (w_y_sum[c_sum_w-1])
      w_y_adj = w_y_sum + c_y_max + c_sum_w'(1);
    else if (w_y_sum > c_y_max)
      w_y_adj = w_y_sum - c_y_max - c_sum_w'(1);
`else
    if (w_y_sum[c_sum_w-1])
      w_y_adj = '0;
    else if (w_y_sum > c_y_max)
      w_y_adj = c_y_max;
`endif
    w_y_next = w_y_adj[COORD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_paddle_y <= c_init_y;
      r_pending  <= '0;
    end else if (frame_start) begin
      r_paddle_y <= w_y_next;
      r_pending  <= $signed({{(c_pend_w - 2){w_step[1]}}, w_step});
    end else begin
      r_pending  <= w_pend_sat;
    end
  end

  assign paddle_y  = r_paddle_y;
  assign at_top    = (r_paddle_y == '0);
  assign at_bottom = (r_paddle_y == c_y_max_u);

  // Paddle span ends, widened by one bit so top+height never wraps.
  logic [COORD_W:0] w_pad_top;
  logic [COORD_W:0] w_pad_bot;
  logic [COORD_W:0] w_px;
  logic [COORD_W:0] w_py;
  logic             w_pix_in;

  assign w_pad_top = {1'b0, r_paddle_y};
  assign w_pad_bot = w_pad_top + c_ph;
  assign w_px      = {1'b0, pixel_x};
  assign w_py      = {1'b0, pixel_y};
  assign w_pix_in  = (w_px >= c_x_lo) && (w_px < c_x_hi) &&
                     (w_py >= w_pad_top) && (w_py < w_pad_bot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on_valid <= 1'b0;
      pixel_on       <= 1'b0;
    end else begin
      pixel_on_valid <= pixel_valid;
      pixel_on       <= pixel_valid & w_pix_in;
    end
  end

  logic             r_s1_valid;
  logic             r_s1_ball_nz;
  logic [COORD_W:0] r_s1_ball_top;
  logic [COORD_W:0] r_s1_ball_bot;
  logic [COORD_W:0] r_s1_ball_mid;
  logic [COORD_W:0] r_s1_pad_top;
  logic [COORD_W:0] r_s1_pad_bot;
  logic [COORD_W:0] r_s1_pad_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_ball_nz  <= 1'b0;
      r_s1_ball_top <= '0;
      r_s1_ball_bot <= '0;
      r_s1_ball_mid <= '0;
      r_s1_pad_top  <= '0;
      r_s1_pad_bot  <= '0;
      r_s1_pad_mid  <= '0;
    end else begin
      r_s1_valid <= hit_req;
      if (hit_req) begin
        r_s1_ball_nz  <= (ball_height != '0);
        r_s1_ball_top <= {1'b0, ball_y};
        r_s1_ball_bot <= {1'b0, ball_y} + {1'b0, ball_height};
        r_s1_ball_mid <= {1'b0, ball_y} + {2'b00, ball_height[COORD_W-1:1]};
        r_s1_pad_top  <= w_pad_top;
        r_s1_pad_bot  <= w_pad_bot;
        r_s1_pad_mid  <= w_pad_top + c_ph_half;
      end
    end
  end

  logic signed [COORD_W+1:0] w_offset;
  logic                      w_hit;

  // A zero-height ball has an empty span and can never overlap.
  assign w_hit    = r_s1_ball_nz && (r_s1_ball_top < r_s1_pad_bot) &&
                    (r_s1_ball_bot > r_s1_pad_top);
  assign w_offset = $signed({1'b0, r_s1_ball_mid}) - $signed({1'b0, r_s1_pad_mid});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_ack    <= 1'b0;
      hit        <= 1'b0;
      hit_offset <= '0;
    end else begin
      hit_ack <= r_s1_valid;
      if (r_s1_valid) begin
        hit        <= w_hit;
        hit_offset <= w_offset[COORD_W:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paddle_position_tracker.sv
// Self-checking bench for paddle_position_tracker: arithmetic reference model checked
// every cycle, plus literal expectations at key points of the directed sequence.
`default_nettype none

module tb_paddle_position_tracker;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [1:0] position_change;
  logic              frame_start;
  logic              pixel_valid;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              pixel_on;
  logic              pixel_on_valid;
  logic              hit_req;
  logic [9:0]        ball_y;
  logic [9:0]        ball_height;
  logic              hit_ack;
  logic              hit;
  logic signed [10:0] hit_offset;
  logic [9:0]        paddle_y;
  logic              at_top;
  logic              at_bottom;

  paddle_position_tracker dut (
    .clk(clk), .rst(rst), .position_change(position_change), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_on(pixel_on), .pixel_on_valid(pixel_on_valid),
    .hit_req(hit_req), .ball_y(ball_y), .ball_height(ball_height),
    .hit_ack(hit_ack), .hit(hit), .hit_offset(hit_offset),
    .paddle_y(paddle_y), .at_top(at_top), .at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the outputs must show in the current cycle.
  int m_y, m_p;
  bit m_pv, m_po;
  bit m_s1v, m_s1h;
  int m_s1o;
  bit m_ack, m_hit;
  int m_off;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 208; m_p = 0;
    m_pv = 0; m_po = 0;
    m_s1v = 0; m_s1h = 0; m_s1o = 0;
    m_ack = 0; m_hit = 0; m_off = 0;
  endtask

  function automatic int commit_y(input int t);
`ifdef PADDLE_WRAP_EN
    if (t < 0) return t + 417;
    if (t > 416) return t - 417;
    return t;
`else
    if (t < 0) return 0;
    if (t > 416) return 416;
    return t;
`endif
  endfunction

  task automatic clear_inputs();
    position_change = 2'sb00; frame_start = 0;
    pixel_valid = 0; pixel_x = '0; pixel_y = '0;
    hit_req = 0; ball_y = '0; ball_height = '0;
  endtask

  // Advance one clock: predict from current inputs, clock, then adopt prediction.
  task automatic next();
    int d, ny, np, ns1o, noff, px, py, by, bh;
    bit npo, ns1h, nhit;
    d  = (position_change == 2'sb01) ? 1 : (position_change == 2'sb11) ? -1 : 0;
    px = int'(pixel_x); py = int'(pixel_y);
    by = int'(ball_y);  bh = int'(ball_height);
    if (frame_start) begin
      ny = commit_y(m_y + m_p);
      np = d;
    end else begin
      ny = m_y;
      np = m_p + d;
      if (np > 15) np = 15;
      if (np < -15) np = -15;
    end
    npo  = pixel_valid && px >= 16 && px < 24 && py >= m_y && py < m_y + 64;
    nhit = m_s1v ? m_s1h : m_hit;
    noff = m_s1v ? m_s1o : m_off;
    ns1h = m_s1h; ns1o = m_s1o;
    if (hit_req) begin
      ns1h = (bh != 0) && (by < m_y + 64) && (by + bh > m_y);
      ns1o = (by + bh / 2) - (m_y + 32);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_ack = m_s1v; m_hit = nhit; m_off = noff;
      m_s1v = hit_req; m_s1h = ns1h; m_s1o = ns1o;
      m_pv = pixel_valid; m_po = npo;
      m_y = ny; m_p = np;
    end
    clear_inputs();
  endtask

  task automatic ticks(input int n, input logic signed [1:0] pc);
    for (int i = 0; i < n; i++) begin
      position_change = pc;
      next();
    end
  endtask

  task automatic frame();
    frame_start = 1;
    next();
  endtask

  task automatic pix(input int x, input int y);
    pixel_valid = 1; pixel_x = 10'(x); pixel_y = 10'(y);
  endtask

  task automatic req(input int by, input int bh);
    hit_req = 1; ball_y = 10'(by); ball_height = 10'(bh);
  endtask

  always @(negedge clk) begin
    check("paddle_y", paddle_y, m_y);
    check("at_top", at_top, int'(m_y == 0));
    check("at_bottom", at_bottom, int'(m_y == 416));
    check("pixel_on_valid", pixel_on_valid, int'(m_pv));
    check("pixel_on", pixel_on, int'(m_po));
    check("hit_ack", hit_ack, int'(m_ack));
    check("hit", hit, int'(m_hit));
    check("hit_offset", $signed(hit_offset), m_off);
  end

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    repeat (3) next();
    rst = 0;
    repeat (10) next();
    check("lit_reset_y", paddle_y, 208);
    check("lit_reset_top", at_top, 0);
    check("lit_reset_bot", at_bottom, 0);
    check("lit_reset_ack", hit_ack, 0);

    // Five +1 ticks with an illegal 2'b10 tick mixed in
    ticks(3, 2'sb01);
    ticks(1, 2'sb10);
    ticks(2, 2'sb01);
    check("lit_pre_commit", paddle_y, 208);
    frame();
    check("lit_commit_5", paddle_y, 213);

    // Saturate at -15, then two opposite ticks bring pending to -13
    ticks(20, 2'sb11);
    ticks(2, 2'sb01);
    frame();
    check("lit_sat_commit", paddle_y, 200);
    for (int k = 0; k < 13; k++) begin
      ticks(20, 2'sb11);
      frame();
    end
    check("lit_walk_up", paddle_y, 5);
    ticks(5, 2'sb11);
    frame();
    check("lit_reach_top", paddle_y, 0);
    check("lit_at_top", at_top, 1);
    ticks(15, 2'sb11);
    frame();
`ifdef PADDLE_WRAP_EN
    check("lit_wrap_top", paddle_y, 402);
`else
    check("lit_clamp_top", paddle_y, 0);
`endif

    // Reset with queries in flight
    pix(16, 0); req(0, 8);
    next();
    pix(16, 0); req(0, 8);
    #2;
    rst = 1;
    model_reset();
    next();
    next();
    rst = 0;
    repeat (4) next();
    check("lit_rst_y", paddle_y, 208);
    check("lit_rst_valid", pixel_on_valid, 0);

    // Commit with zero pending, coincident tick carried into next frame
    position_change = 2'sb01;
    frame();
    check("lit_zero_pend", paddle_y, 208);
    frame();
    check("lit_carry_tick", paddle_y, 209);
    ticks(1, 2'sb11);
    frame();
    check("lit_back_208", paddle_y, 208);

    // Back-to-back pixel queries
    pix(16, 208);  next();
    check("lit_pix_a", pixel_on, 1);
    pix(24, 208);  next();
    check("lit_pix_b", pixel_on, 0);
    check("lit_pix_b_v", pixel_on_valid, 1);
    pix(16, 272);  next();
    check("lit_pix_c", pixel_on, 0);
    pix(23, 271);  next();
    check("lit_pix_d", pixel_on, 1);
    next();

    // Back-to-back collision requests
    req(232, 8);  next();
    check("lit_ack_early", hit_ack, 0);
    req(272, 8);  next();
    check("lit_ack_a", hit_ack, 1);
    check("lit_hit_a", hit, 1);
    check("lit_off_a", $signed(hit_offset), -4);
    req(240, 0);  next();
    check("lit_hit_b", hit, 0);
    req(200, 9);  next();
    check("lit_hit_c", hit, 0);
    next();
    check("lit_hit_d", hit, 1);
    next();
    check("lit_ack_idle", hit_ack, 0);
    check("lit_hold_off", $signed(hit_offset), (200 + 4) - 240);

    // Drive towards the bottom
    for (int k = 0; k < 14; k++) begin
      ticks(15, 2'sb01);
      frame();
    end
`ifdef PADDLE_WRAP_EN
    check("lit_wrap_bot", paddle_y, 1);
`else
    check("lit_clamp_bot", paddle_y, 416);
    check("lit_at_bottom", at_bottom, 1);
`endif
    pix(16, 479); next();
    req(470, 20); next();
    repeat (3) next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
